// File: rtl/bpred_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpred_pkg
// Description : Shared types and widths for the branch-predictor update path.
// Revision    : 1.0 - initial release
// ============================================================================
package bpred_pkg;

  localparam int BPRED_DATA_W = 96;
  localparam int BPRED_META_W = 4;

  // One resolved branch as seen by the predictor update port
  typedef struct packed {
    logic [31:0]             PC4;
    logic [31:0]             target;
    logic                    dir;
    logic                    miss;
    logic [BPRED_DATA_W-1:0] data;
    logic [BPRED_META_W-1:0] meta;
    logic                    recover_ras;
  } bpred_update_t;

endpackage
`default_nettype wire

// File: rtl/bpred_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : bpred_fifo_ptr
// Description : Head/tail pointers and occupancy counter for a power-of-two
//               circular buffer. Pointers wrap naturally at DEPTH-1 -> 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bpred_fifo_ptr #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [PTR_W:0]   count
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  // Advance pointers on push/pop; count only moves when exactly one happens
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_tail <= r_tail + 1'b1;
      if (pop)  r_head <= r_head + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_head;
  assign tail  = r_tail;
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/bpred_update_queue.sv
`default_nettype none
// ============================================================================
// Module      : bpred_update_queue
// Description : In-order decoupling FIFO between execute and the branch
//               predictor update port. Absorbs predictor stalls, returns
//               backpressure to execute when full, flags dropped updates.
// Revision    : 1.0 - initial release
// ============================================================================
module bpred_update_queue
  import bpred_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    execute_update,
  input  logic [31:0]             execute_PC4,
  input  logic [31:0]             execute_target,
  input  logic                    execute_dir,
  input  logic                    execute_miss,
  input  logic [BPRED_DATA_W-1:0] execute_data,
  input  logic [BPRED_META_W-1:0] execute_meta,
  input  logic                    execute_recover_ras,
  output logic                    execute_stall,
  input  logic                    soin_bpredictor_stall,
  output logic                    execute_bpredictor_update,
  output logic [31:0]             execute_bpredictor_PC4,
  output logic [31:0]             execute_bpredictor_target,
  output logic                    execute_bpredictor_dir,
  output logic                    execute_bpredictor_miss,
  output logic [BPRED_DATA_W-1:0] execute_bpredictor_data,
  output logic [BPRED_META_W-1:0] execute_bpredictor_meta,
  output logic                    execute_bpredictor_recover_ras,
  output logic [PTR_W:0]          occupancy,
  output logic                    overflow_err
);

  localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

  bpred_update_t    r_mem [DEPTH];
  logic             r_overflow;
  logic [PTR_W-1:0] w_head;
  logic [PTR_W-1:0] w_tail;
  logic [PTR_W:0]   w_count;
  logic             w_nonempty;
  logic             w_pop;
  logic             w_push;
  bpred_update_t    w_in;
  bpred_update_t    w_head_entry;

  assign w_nonempty = (w_count != '0);
  assign w_pop      = w_nonempty & ~soin_bpredictor_stall;
  // A full queue that drains this cycle still has room for one more entry
  assign execute_stall = (w_count == c_depth) & ~w_pop;
  assign w_push        = execute_update & ~execute_stall;

  assign w_in = '{PC4:         execute_PC4,
                  target:      execute_target,
                  dir:         execute_dir,
                  miss:        execute_miss,
                  data:        execute_data,
                  meta:        execute_meta,
                  recover_ras: execute_recover_ras};

  bpred_fifo_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .head  (w_head),
    .tail  (w_tail),
    .count (w_count)
  );

  // Entry storage: cleared on reset, written at the tail on an accepted push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[w_tail] <= w_in;
    end
  end

  // Sticky flag for an update offered while the queue refused it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                r_overflow <= 1'b0;
    else if (execute_update && execute_stall)  r_overflow <= 1'b1;
  end

  // Head is forced to zero when empty so stale storage never leaks out
  assign w_head_entry = w_nonempty ? r_mem[w_head] : '0;

  assign execute_bpredictor_update      = w_pop;
  assign execute_bpredictor_PC4         = w_head_entry.PC4;
  assign execute_bpredictor_target      = w_head_entry.target;
  assign execute_bpredictor_dir         = w_head_entry.dir;
  assign execute_bpredictor_miss        = w_head_entry.miss;
  assign execute_bpredictor_data        = w_head_entry.data;
  assign execute_bpredictor_meta        = w_head_entry.meta;
  assign execute_bpredictor_recover_ras = w_head_entry.recover_ras;
  assign occupancy                      = w_count;
  assign overflow_err                   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bpred_update_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpred_update_queue
// Description : Self-checking bench for bpred_update_queue. A queue-based
//               reference model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpred_update_queue;
  import bpred_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    execute_update;
  logic [31:0]             execute_PC4;
  logic [31:0]             execute_target;
  logic                    execute_dir;
  logic                    execute_miss;
  logic [BPRED_DATA_W-1:0] execute_data;
  logic [BPRED_META_W-1:0] execute_meta;
  logic                    execute_recover_ras;
  logic                    execute_stall;
  logic                    soin_bpredictor_stall;
  logic                    execute_bpredictor_update;
  logic [31:0]             execute_bpredictor_PC4;
  logic [31:0]             execute_bpredictor_target;
  logic                    execute_bpredictor_dir;
  logic                    execute_bpredictor_miss;
  logic [BPRED_DATA_W-1:0] execute_bpredictor_data;
  logic [BPRED_META_W-1:0] execute_bpredictor_meta;
  logic                    execute_bpredictor_recover_ras;
  logic [PTR_W:0]          occupancy;
  logic                    overflow_err;

  bpred_update_queue #(.DEPTH(DEPTH)) dut (
    .clk                            (clk),
    .reset                          (reset),
    .execute_update                 (execute_update),
    .execute_PC4                    (execute_PC4),
    .execute_target                 (execute_target),
    .execute_dir                    (execute_dir),
    .execute_miss                   (execute_miss),
    .execute_data                   (execute_data),
    .execute_meta                   (execute_meta),
    .execute_recover_ras            (execute_recover_ras),
    .execute_stall                  (execute_stall),
    .soin_bpredictor_stall          (soin_bpredictor_stall),
    .execute_bpredictor_update      (execute_bpredictor_update),
    .execute_bpredictor_PC4         (execute_bpredictor_PC4),
    .execute_bpredictor_target      (execute_bpredictor_target),
    .execute_bpredictor_dir         (execute_bpredictor_dir),
    .execute_bpredictor_miss        (execute_bpredictor_miss),
    .execute_bpredictor_data        (execute_bpredictor_data),
    .execute_bpredictor_meta        (execute_bpredictor_meta),
    .execute_bpredictor_recover_ras (execute_bpredictor_recover_ras),
    .occupancy                      (occupancy),
    .overflow_err                   (overflow_err)
  );

  always #5 clk = ~clk;

  bpred_update_t obs_head;
  assign obs_head = {execute_bpredictor_PC4, execute_bpredictor_target,
                     execute_bpredictor_dir, execute_bpredictor_miss,
                     execute_bpredictor_data, execute_bpredictor_meta,
                     execute_bpredictor_recover_ras};

  // Reference model: in-order list of accepted entries plus sticky error
  bpred_update_t mq[$];
  logic          m_ovf;
  int            n_vec;
  int            n_err;

  task automatic chk(input string tag, input logic [166:0] obs, input logic [166:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bpred_update_t mk(input logic [31:0] pc4);
    bpred_update_t e;
    e = '0;
    e.PC4    = pc4;
    e.target = pc4 + 32'h40;
    e.meta   = pc4[3:0];
    e.data   = {64'd0, pc4};
    return e;
  endfunction

  function automatic bpred_update_t rnd();
    bpred_update_t e;
    e.PC4         = $urandom;
    e.target      = $urandom;
    e.dir         = 1'($urandom_range(0, 1));
    e.miss        = 1'($urandom_range(0, 1));
    e.data        = {$urandom, $urandom, $urandom};
    e.meta        = 4'($urandom_range(0, 15));
    e.recover_ras = 1'($urandom_range(0, 1));
    return e;
  endfunction

  task automatic drive(input logic upd, input bpred_update_t d, input logic stl);
    execute_update        = upd;
    execute_PC4           = d.PC4;
    execute_target        = d.target;
    execute_dir           = d.dir;
    execute_miss          = d.miss;
    execute_data          = d.data;
    execute_meta          = d.meta;
    execute_recover_ras   = d.recover_ras;
    soin_bpredictor_stall = stl;
  endtask

  // One clock: drive, compare all outputs against the model, advance model
  task automatic step(input logic upd, input bpred_update_t d, input logic stl);
    logic          exp_pop;
    logic          exp_stall;
    bpred_update_t exp_head;
    drive(upd, d, stl);
    #1;
    exp_pop   = (mq.size() != 0) && !stl;
    exp_stall = (mq.size() == DEPTH) && !exp_pop;
    exp_head  = (mq.size() != 0) ? mq[0] : '0;
    chk("update",    execute_bpredictor_update, exp_pop);
    chk("stall",     execute_stall, exp_stall);
    chk("head",      obs_head, exp_head);
    chk("occupancy", occupancy, mq.size());
    chk("overflow",  overflow_err, m_ovf);
    if (exp_pop) void'(mq.pop_front());
    if (upd && !exp_stall) mq.push_back(d);
    if (upd && exp_stall) m_ovf = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Idle inputs and let combinational outputs settle for a directed look
  task automatic peek(input logic stl);
    drive(1'b0, '0, stl);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_ovf = 1'b0;
    reset = 1'b0;
    drive(1'b0, '0, 1'b0);

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    peek(1'b0);
    chk("rst_occ",    occupancy, 0);
    chk("rst_update", execute_bpredictor_update, 0);
    chk("rst_stall",  execute_stall, 0);
    chk("rst_head",   obs_head, 0);
    chk("rst_ovf",    overflow_err, 0);
    step(1'b0, '0, 1'b0);

    // Single pass-through
    begin
      bpred_update_t e;
      e = '0;
      e.PC4 = 32'h80; e.target = 32'h100; e.dir = 1'b1;
      e.data = 96'hFFFF; e.meta = 4'h3;
      step(1'b1, e, 1'b0);
      peek(1'b0);
      chk("pass_update", execute_bpredictor_update, 1);
      chk("pass_fields", obs_head, e);
      step(1'b0, '0, 1'b0);
      peek(1'b0);
      chk("pass_drained", occupancy, 0);
    end

    // Fill under stall, then drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, mk(32'(4 * i)), 1'b1);
    peek(1'b1);
    chk("fill_occ",   occupancy, 4);
    chk("fill_stall", execute_stall, 1);
    for (int i = 1; i <= 4; i++) begin
      peek(1'b0);
      chk("drain_update", execute_bpredictor_update, 1);
      chk("drain_pc4",    execute_bpredictor_PC4, 32'(4 * i));
      step(1'b0, '0, 1'b0);
    end

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) step(1'b1, mk(32'(4 * i)), 1'b1);
    peek(1'b0);
    chk("full_pp_stall", execute_stall, 0);
    step(1'b1, mk(32'd20), 1'b0);
    peek(1'b0);
    chk("full_pp_occ", occupancy, 4);
    for (int i = 2; i <= 4; i++) step(1'b0, '0, 1'b0);
    peek(1'b0);
    chk("full_pp_fifth", execute_bpredictor_PC4, 32'd20);
    step(1'b0, '0, 1'b0);

    // Overflow: offered while full and stalled is dropped
    for (int i = 1; i <= 4; i++) step(1'b1, mk(32'(4 * i)), 1'b1);
    step(1'b1, mk(32'h99), 1'b1);
    peek(1'b1);
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_occ",  occupancy, 4);
    for (int i = 1; i <= 4; i++) step(1'b0, '0, 1'b0);
    peek(1'b0);
    chk("ovf_empty",  occupancy, 0);
    chk("ovf_sticky", overflow_err, 1);

    // Ten push/pop pairs across pointer wrap
    for (int i = 0; i < 10; i++) step(1'b1, rnd(), 1'b0);
    step(1'b0, '0, 1'b0);

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) step(1'b1, rnd(), 1'b1);
    peek(1'b0);
    chk("pre_rst_occ", occupancy, 3);
    #1;
    reset = 1'b0;
    #1;
    chk("async_occ",    occupancy, 0);
    chk("async_update", execute_bpredictor_update, 0);
    chk("async_head",   obs_head, 0);
    chk("async_ovf",    overflow_err, 0);
    mq.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Randomised traffic, including occasional protocol violations
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), rnd(), 1'($urandom_range(0, 2) == 0));
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
